// File: rtl/code_entry_sequencer.sv
// Four-digit code entry: debounced buttons feed a digit collector
// that hands a 16-bit frame to the lock checker over valid/ready.

module code_entry_debounce #(
    parameter int unsigned CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_pulse
);

    localparam int unsigned CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic          r_s1;
    logic          r_s2;
    logic          r_level;
    logic          r_level_d;
    logic [CW-1:0] r_cnt;

    // A new level is taken only after CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1      <= i_raw;
            r_s2      <= r_s1;
            r_level_d <= r_level;
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(CYCLES - 1)) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_pulse = r_level & ~r_level_d;

endmodule

module code_entry_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_enter,
    input  logic        btn_clear,
    input  logic [3:0]  sw,
    input  logic        code_ready,
    output logic        code_valid,
    output logic [15:0] code_data,
    output logic [15:0] entry_digits,
    output logic [2:0]  digit_count,
    output logic        timeout_pulse,
    output logic        drop_err
);

    localparam int unsigned TW =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_SEND
    } state_t;

    state_t        r_state;
    logic [15:0]   r_entry;
    logic [2:0]    r_count;
    logic [TW-1:0] r_timer;
    logic          r_tmo;
    logic          r_drop;

    state_t        w_state_nxt;
    logic [15:0]   w_entry_nxt;
    logic [2:0]    w_count_nxt;
    logic [TW-1:0] w_timer_nxt;
    logic          w_tmo_nxt;
    logic          w_drop_nxt;

    logic          w_ent;
    logic          w_clr;
    logic [15:0]   w_ins;

    code_entry_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_db_enter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (btn_enter),
        .o_pulse (w_ent)
    );

    code_entry_debounce #(
        .CYCLES (DEBOUNCE_CYCLES)
    ) u_db_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (btn_clear),
        .o_pulse (w_clr)
    );

    // Digit n lands in nibble 3-n, so the first digit ends up in [15:12].
    assign w_ins = 16'(sw) << {~r_count[1:0], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_entry <= '0;
            r_count <= '0;
            r_timer <= '0;
            r_tmo   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_entry <= w_entry_nxt;
            r_count <= w_count_nxt;
            r_timer <= w_timer_nxt;
            r_tmo   <= w_tmo_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_count_nxt = r_count;
        w_timer_nxt = r_timer;
        w_tmo_nxt   = 1'b0;
        w_drop_nxt  = r_drop;
        unique case (r_state)
            ST_IDLE: begin
                if (w_ent && !w_clr) begin
                    w_entry_nxt = r_entry | w_ins;
                    w_count_nxt = 3'd1;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (w_clr) begin
                    w_entry_nxt = '0;
                    w_count_nxt = '0;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_ent) begin
                    w_entry_nxt = r_entry | w_ins;
                    w_count_nxt = r_count + 3'd1;
                    w_timer_nxt = '0;
                    if (r_count == 3'd3) begin
                        w_state_nxt = ST_SEND;
                    end
                end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    w_entry_nxt = '0;
                    w_count_nxt = '0;
                    w_timer_nxt = '0;
                    w_tmo_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_timer_nxt = r_timer + 1'b1;
                end
            end
            ST_SEND: begin
                // Clear is ignored here; only a transfer leaves SEND.
                if (w_ent) begin
                    w_drop_nxt = 1'b1;
                end
                if (code_ready) begin
                    w_entry_nxt = '0;
                    w_count_nxt = '0;
                    w_timer_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_entry_nxt = '0;
                w_count_nxt = '0;
                w_timer_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign code_valid    = (r_state == ST_SEND);
    assign code_data     = code_valid ? r_entry : 16'h0000;
    assign entry_digits  = r_entry;
    assign digit_count   = r_count;
    assign timeout_pulse = r_tmo;
    assign drop_err      = r_drop;

endmodule

// File: tb/tb_code_entry_sequencer.sv
// Directed bench for code_entry_sequencer with short debounce
// and timeout settings; expected values are worked out by hand.

module tb_code_entry_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_enter = 1'b0;
    logic        btn_clear = 1'b0;
    logic [3:0]  sw = 4'h0;
    logic        code_ready = 1'b0;
    logic        code_valid;
    logic [15:0] code_data;
    logic [15:0] entry_digits;
    logic [2:0]  digit_count;
    logic        timeout_pulse;
    logic        drop_err;

    int n_checks = 0;
    int n_errors = 0;

    int          n_valid = 0;
    int          n_xfer = 0;
    int          n_tmo = 0;
    int          n_unstable = 0;
    logic [15:0] xfer_data = 16'h0;
    logic [15:0] prev_data = 16'h0;
    logic        prev_valid = 1'b0;

    code_entry_sequencer #(
        .DEBOUNCE_CYCLES (4),
        .TIMEOUT_CYCLES  (64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_enter     (btn_enter),
        .btn_clear     (btn_clear),
        .sw            (sw),
        .code_ready    (code_ready),
        .code_valid    (code_valid),
        .code_data     (code_data),
        .entry_digits  (entry_digits),
        .digit_count   (digit_count),
        .timeout_pulse (timeout_pulse),
        .drop_err      (drop_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (code_valid) n_valid <= n_valid + 1;
        if (code_valid && code_ready) begin
            n_xfer    <= n_xfer + 1;
            xfer_data <= code_data;
        end
        if (timeout_pulse) n_tmo <= n_tmo + 1;
        if (code_valid && prev_valid && code_data != prev_data)
            n_unstable <= n_unstable + 1;
        prev_valid <= code_valid;
        prev_data  <= code_data;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        sw = v;
        btn_enter = 1'b1;
        cyc(10);
        btn_enter = 1'b0;
        cyc(10);
    endtask

    task automatic press_clr();
        btn_clear = 1'b1;
        cyc(10);
        btn_clear = 1'b0;
        cyc(10);
    endtask

    task automatic press_both(input logic [3:0] v);
        sw = v;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        cyc(10);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        cyc(10);
    endtask

    initial begin
        int v0, x0, u0, t0, k;

        cyc(3);
        chk("rst_valid", 32'(code_valid), 32'd0);
        chk("rst_data", 32'(code_data), 32'd0);
        chk("rst_entry", 32'(entry_digits), 32'd0);
        chk("rst_count", 32'(digit_count), 32'd0);
        chk("rst_tmo", 32'(timeout_pulse), 32'd0);
        chk("rst_drop", 32'(drop_err), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        code_ready = 1'b1;
        press(4'hB);
        press(4'hF);
        press(4'h1);
        chk("b1_count3", 32'(digit_count), 32'd3);
        chk("b1_entry3", 32'(entry_digits), 32'hBF10);
        chk("b1_novalid", 32'(code_valid), 32'd0);
        v0 = n_valid;
        x0 = n_xfer;
        press(4'h2);
        chk("b1_vcycles", 32'(n_valid - v0), 32'd1);
        chk("b1_xfers", 32'(n_xfer - x0), 32'd1);
        chk("b1_data", 32'(xfer_data), 32'hBF12);
        chk("b1_count0", 32'(digit_count), 32'd0);
        chk("b1_entry0", 32'(entry_digits), 32'd0);

        code_ready = 1'b0;
        press(4'hB);
        press(4'hF);
        press(4'h1);
        v0 = n_valid;
        x0 = n_xfer;
        u0 = n_unstable;
        sw = 4'h2;
        btn_enter = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!code_valid && k < 50);
        chk("b2_send", 32'(code_valid), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        code_ready = 1'b1;
        cyc(1);
        btn_enter = 1'b0;
        cyc(12);
        chk("b2_vcycles", 32'(n_valid - v0), 32'd21);
        chk("b2_xfers", 32'(n_xfer - x0), 32'd1);
        chk("b2_data", 32'(xfer_data), 32'hBF12);
        chk("b2_stable", 32'(n_unstable - u0), 32'd0);
        chk("b2_idle", 32'(code_valid), 32'd0);
        chk("b2_count", 32'(digit_count), 32'd0);

        sw = 4'h9;
        for (int i = 0; i < 15; i++) begin
            btn_enter = ~btn_enter;
            cyc(2);
        end
        btn_enter = 1'b1;
        cyc(20);
        btn_enter = 1'b0;
        cyc(15);
        chk("bounce_count", 32'(digit_count), 32'd1);
        chk("bounce_entry", 32'(entry_digits), 32'h9000);

        press_both(4'h8);
        chk("both_count", 32'(digit_count), 32'd0);
        chk("both_entry", 32'(entry_digits), 32'd0);
        press_clr();
        chk("clr_idle_count", 32'(digit_count), 32'd0);
        chk("clr_idle_valid", 32'(code_valid), 32'd0);

        press(4'h3);
        press(4'h4);
        chk("c_count2", 32'(digit_count), 32'd2);
        chk("c_entry2", 32'(entry_digits), 32'h3400);
        press_clr();
        chk("c_clr_count", 32'(digit_count), 32'd0);
        chk("c_clr_entry", 32'(entry_digits), 32'd0);
        x0 = n_xfer;
        for (int i = 0; i < 4; i++) press(4'h5);
        chk("c_xfers", 32'(n_xfer - x0), 32'd1);
        chk("c_data", 32'(xfer_data), 32'h5555);
        chk("c_count0", 32'(digit_count), 32'd0);

        press(4'h7);
        cyc(40);
        chk("t_early", 32'(digit_count), 32'd1);
        t0 = n_tmo;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!timeout_pulse && k < 40);
        chk("t_seen", 32'(timeout_pulse), 32'd1);
        cyc(3);
        chk("t_width", 32'(n_tmo - t0), 32'd1);
        chk("t_count", 32'(digit_count), 32'd0);
        chk("t_entry", 32'(entry_digits), 32'd0);

        code_ready = 1'b0;
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(4'h4);
        chk("s_valid", 32'(code_valid), 32'd1);
        chk("s_data", 32'(code_data), 32'h1234);
        chk("s_nodrop", 32'(drop_err), 32'd0);
        press(4'h9);
        chk("s_drop", 32'(drop_err), 32'd1);
        chk("s_data_kept", 32'(code_data), 32'h1234);
        press_clr();
        chk("s_clr_ignored", 32'(code_valid), 32'd1);
        t0 = n_tmo;
        cyc(80);
        chk("s_no_tmo", 32'(n_tmo - t0), 32'd0);
        chk("s_still_valid", 32'(code_valid), 32'd1);
        chk("s_drop_sticky", 32'(drop_err), 32'd1);

        #2;
        rst_n = 1'b0;
        #1;
        chk("r_valid", 32'(code_valid), 32'd0);
        chk("r_data", 32'(code_data), 32'd0);
        chk("r_entry", 32'(entry_digits), 32'd0);
        chk("r_count", 32'(digit_count), 32'd0);
        chk("r_drop", 32'(drop_err), 32'd0);
        chk("r_tmo", 32'(timeout_pulse), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        press(4'h6);
        chk("r_fresh_count", 32'(digit_count), 32'd1);
        chk("r_fresh_entry", 32'(entry_digits), 32'h6000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/code_entry_sequencer.md
CODE_ENTRY_SEQUENCER -- requirements
Module: code_entry_sequencer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: the number of consecutive stable synchronized samples a button needs before its new level is accepted.
REQ-002 Parameter TIMEOUT_CYCLES, default 500000000: the number of idle cycles after which a partial entry is discarded.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 btn_enter  input  1  raw, asynchronous, bouncing digit-enter button.
REQ-006 btn_clear  input  1  raw, asynchronous, bouncing clear button.
REQ-007 sw  input  4  digit value; sampled only on an accepted enter press.
REQ-008 code_ready  input  1  lock checker can accept a code frame.
REQ-009 code_valid  output  1  a complete 4-digit code frame is presented.
REQ-010 code_data  output  16  code frame; first-entered digit in [15:12], last in [3:0].
REQ-011 entry_digits  output  16  partial entry for the display, in the same packing as code_data, with unfilled nibbles at 0.
REQ-012 digit_count  output  3  digits held, 0..4.
REQ-013 timeout_pulse  output  1  one-cycle pulse when a partial entry is discarded by timeout.
REQ-014 drop_err  output  1  sticky flag: an enter press was ignored while SEND.

Function
REQ-015 Each button SHALL pass through a 2-flop synchronizer, then a debounce counter that requires DEBOUNCE_CYCLES identical consecutive samples, then a rising-edge detector that produces a one-cycle press pulse.
REQ-016 Press-pulse latency SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles (±1) after a clean raw rising edge; bounces shorter than DEBOUNCE_CYCLES SHALL produce no pulse.
REQ-017 The FSM SHALL have three states: IDLE (count 0), COLLECT (count 1..3), SEND (count 4).
REQ-018 On an enter pulse in IDLE or COLLECT, the block SHALL shift sw into the entry (next free nibble, MSB-first) and increment digit_count.
REQ-019 When the 4th digit is accepted, the FSM SHALL enter SEND on the next cycle; code_valid=1 and code_data equals the 4 digits.
REQ-020 In SEND, code_valid and code_data SHALL remain stable until the cycle in which code_valid && code_ready; that cycle is the transfer.
REQ-021 After the transfer, the block SHALL go to IDLE on the next cycle with code_valid=0, digit_count=0 and entry_digits=0.
REQ-022 A clear pulse in COLLECT SHALL return the FSM to IDLE with count 0 and entry 0; a clear pulse in IDLE has no effect.
REQ-023 A clear pulse in SEND SHALL be ignored, so code_valid never drops without a transfer.
REQ-024 Enter and clear pulses in the same cycle: clear wins and the digit is not stored.
REQ-025 An enter pulse in SEND SHALL be discarded and SHALL set drop_err; drop_err clears only on reset.
REQ-026 The idle timer SHALL run only in COLLECT and SHALL restart on every enter pulse.
REQ-027 When the idle timer reaches TIMEOUT_CYCLES, the block SHALL clear the entry, go to IDLE and assert timeout_pulse for 1 cycle.
REQ-028 The idle timer SHALL not run in SEND, so a waiting frame never times out.
REQ-029 All 16 sw values (0x0..0xF) are valid digits.

Reset
REQ-030 While rst_n=0, the block SHALL hold: FSM=IDLE; code_valid=0; code_data=0; entry_digits=0; digit_count=0; timeout_pulse=0; drop_err=0; all synchronizer, debounce and timer registers at 0.
REQ-031 Reset asserted mid-entry or mid-SEND SHALL drop the frame immediately (asynchronous); after release, the first press is handled as a fresh entry.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64)
REQ-032 Enter presses with sw=B, F, 1, 2 and code_ready=1 -> code_valid for exactly 1 cycle with code_data=0xBF12, then digit_count=0.
REQ-033 Same 4 presses with code_ready=0 for 20 cycles, then 1 -> code_valid held 21 cycles with code_data stable at 0xBF12; transfer on the first ready cycle.
REQ-034 btn_enter toggling every 2 cycles for 30 cycles, then held high -> exactly one digit accepted, digit_count=1.
REQ-035 Enter sw=3, sw=4, then clear -> digit_count=0 and entry_digits=0; then 4 presses of 5 -> code_data=0x5555.
REQ-036 Enter sw=7, then 64 idle cycles -> timeout_pulse=1 for 1 cycle and digit_count=0; a 5th press in SEND with code_ready=0 -> drop_err=1 and code_data unchanged.
REQ-037 rst_n pulsed low during SEND -> code_valid=0 within the same cycle; all outputs at reset values.
